wb_commit_queue: RTL and testbench



---
 rtl/wb_commit_queue.sv | 108 ++++++++++
 tb/tb_wb_commit_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_queue.sv
// Writeback commit queue: buffers ALU/load results in an in-order FIFO, drains one
// register-file write per cycle, and forwards pending values to two read ports.
module wb_commit_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_rd,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  in_ready,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_data,
  input  logic [ADDR_WIDTH-1:0] address_rs,
  input  logic [ADDR_WIDTH-1:0] address_rt,
  output logic                  fwd_a_hit,
  output logic [DATA_WIDTH-1:0] fwd_a_data,
  output logic                  fwd_b_hit,
  output logic [DATA_WIDTH-1:0] fwd_b_data,
  output logic [ADDR_WIDTH-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                mem [DEPTH];
  logic [PW-1:0]         head, tail;
  logic [ADDR_WIDTH-1:0] count_q;
  logic                  push_ld, push_alu, pop;
  logic [1:0]            n_push;
  entry_t                ld_entry, alu_entry, slot0_entry;

  assign ld_entry  = '{rd: ld_rd,  data: ld_data};
  assign alu_entry = '{rd: alu_rd, data: alu_data};

  // Admission looks only at the current occupancy so two pushes always fit.
  assign in_ready = (count_q <= ADDR_WIDTH'(DEPTH - 2));
  assign push_ld  = ld_valid  && in_ready && (ld_rd  != '0);
  assign push_alu = alu_valid && in_ready && (alu_rd != '0);
  assign n_push   = {1'b0, push_ld} + {1'b0, push_alu};
  assign pop      = (count_q != '0);
  assign count    = count_q;

  // The load is older, so it takes the tail slot when both arrive together.
  assign slot0_entry = push_ld ? ld_entry : alu_entry;

  // NOTE: payload storage has no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ld || push_alu) mem[tail] <= slot0_entry;
    if (push_ld && push_alu) mem[tail + PW'(1)] <= alu_entry;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      tail    <= tail + PW'(n_push);
      head    <= head + PW'(pop);
      count_q <= count_q + ADDR_WIDTH'(n_push) - ADDR_WIDTH'(pop);
      rf_we   <= pop;
      if (pop) begin
        rf_addr <= mem[head].rd;
        rf_data <= mem[head].data;
      end
    end
  end

  // Scan oldest to youngest so the newest matching entry overrides earlier ones.
  function automatic logic [DATA_WIDTH:0] fwd_lookup(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH:0] result;
    logic [PW-1:0]       idx;
    result = '0;
    idx    = '0;
    if (addr != '0) begin
      if (rf_we && (rf_addr == addr)) result = {1'b1, rf_data};
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if ((ADDR_WIDTH'(i) < count_q) && (mem[idx].rd == addr))
          result = {1'b1, mem[idx].data};
      end
    end
    return result;
  endfunction

  assign {fwd_a_hit, fwd_a_data} = fwd_lookup(address_rs);
  assign {fwd_b_hit, fwd_b_data} = fwd_lookup(address_rt);

  overflow_guard: assert property (@(posedge clk) disable iff (!rst_n)
    !((n_push != 2'd0) && (count_q == ADDR_WIDTH'(DEPTH))));

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue: reset, latency, ordering, register zero,
// backpressure, pointer wrap and asynchronous reset mid-burst.
module tb_wb_commit_queue;

  logic        clk, rst_n;
  logic        alu_valid, ld_valid;
  logic [4:0]  alu_rd, ld_rd, address_rs, address_rt;
  logic [31:0] alu_data, ld_data;
  logic        in_ready, rf_we, fwd_a_hit, fwd_b_hit;
  logic [4:0]  rf_addr, count;
  logic [31:0] rf_data, fwd_a_data, fwd_b_data;

  int vectors    = 0;
  int miscompares = 0;

  wb_commit_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .in_ready(in_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .address_rs(address_rs), .address_rt(address_rt),
    .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
    .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alu_valid = 0; ld_valid = 0; alu_rd = 0; ld_rd = 0;
    alu_data = 0; ld_data = 0; address_rs = 0; address_rt = 0;
    #12;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_rf_we: got %0h expected 0", rf_we); end
    vectors++; if (rf_addr !== 5'd0 || rf_data !== 32'd0) begin miscompares++; $display("FAIL reset_rf_bus: got %0h/%0h expected 0/0", rf_addr, rf_data); end
    vectors++; if (count !== 5'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_count_ready: got %0d/%0b expected 0/1", count, in_ready); end
    vectors++; if (fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0 || fwd_a_data !== 32'd0 || fwd_b_data !== 32'd0) begin miscompares++; $display("FAIL reset_fwd: got %0b %0b %0h %0h expected 0 0 0 0", fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'd33; address_rs = 5'd7;
    #1;
    vectors++; if (fwd_a_hit !== 1'b0) begin miscompares++; $display("FAIL single_fwd_same_cycle: got %0b expected 0", fwd_a_hit); end
    tick();
    alu_valid = 0;
    vectors++; if (count !== 5'd1 || rf_we !== 1'b0) begin miscompares++; $display("FAIL single_queued: got count %0d we %0b expected 1 0", count, rf_we); end
    vectors++; if (fwd_a_hit !== 1'b1 || fwd_a_data !== 32'd33) begin miscompares++; $display("FAIL single_fwd_queued: got %0b/%0d expected 1/33", fwd_a_hit, fwd_a_data); end
    tick();
    vectors++; if (rf_we !== 1'b1 || rf_addr !== 5'd7 || rf_data !== 32'd33) begin miscompares++; $display("FAIL single_commit: got %0b/%0d/%0d expected 1/7/33", rf_we, rf_addr, rf_data); end
    vectors++; if (count !== 5'd0 || fwd_a_hit !== 1'b1 || fwd_a_data !== 32'd33) begin miscompares++; $display("FAIL single_fwd_outreg: got count %0d hit %0b data %0d expected 0 1 33", count, fwd_a_hit, fwd_a_data); end
    tick();
    vectors++; if (rf_we !== 1'b0 || rf_addr !== 5'd7 || rf_data !== 32'd33) begin miscompares++; $display("FAIL single_idle_hold: got %0b/%0d/%0d expected 0/7/33", rf_we, rf_addr, rf_data); end
    vectors++; if (fwd_a_hit !== 1'b0 || fwd_a_data !== 32'd0) begin miscompares++; $display("FAIL single_fwd_gone: got %0b/%0h expected 0/0", fwd_a_hit, fwd_a_data); end
  endtask

  task automatic test_dual();
    ld_valid = 1; ld_rd = 5'd5; ld_data = 32'hAAAA;
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hBBBB;
    address_rs = 5'd5;
    tick();
    ld_valid = 0; alu_valid = 0;
    vectors++; if (count !== 5'd2 || in_ready !== 1'b1) begin miscompares++; $display("FAIL dual_count: got %0d/%0b expected 2/1", count, in_ready); end
    vectors++; if (fwd_a_hit !== 1'b1 || fwd_a_data !== 32'hBBBB) begin miscompares++; $display("FAIL dual_fwd_q2: got %0b/%0h expected 1/bbbb", fwd_a_hit, fwd_a_data); end
    tick();
    vectors++; if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'hAAAA) begin miscompares++; $display("FAIL dual_first: got %0b/%0d/%0h expected 1/5/aaaa", rf_we, rf_addr, rf_data); end
    vectors++; if (fwd_a_data !== 32'hBBBB) begin miscompares++; $display("FAIL dual_fwd_q1: got %0h expected bbbb", fwd_a_data); end
    tick();
    vectors++; if (rf_we !== 1'b1 || rf_data !== 32'hBBBB) begin miscompares++; $display("FAIL dual_second: got %0b/%0h expected 1/bbbb", rf_we, rf_data); end
    vectors++; if (fwd_a_hit !== 1'b1 || fwd_a_data !== 32'hBBBB) begin miscompares++; $display("FAIL dual_fwd_outreg: got %0b/%0h expected 1/bbbb", fwd_a_hit, fwd_a_data); end
    tick();
    vectors++; if (rf_we !== 1'b0 || fwd_a_hit !== 1'b0) begin miscompares++; $display("FAIL dual_done: got we %0b hit %0b expected 0 0", rf_we, fwd_a_hit); end
  endtask

  task automatic test_reg_zero();
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1234;
    ld_valid = 1; ld_rd = 5'd3; ld_data = 32'h77;
    address_rs = 5'd3; address_rt = 5'd0;
    tick();
    alu_valid = 0; ld_valid = 0;
    vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL zero_count: got %0d expected 1", count); end
    vectors++; if (fwd_b_hit !== 1'b0 || fwd_b_data !== 32'd0) begin miscompares++; $display("FAIL zero_fwd_b: got %0b/%0h expected 0/0", fwd_b_hit, fwd_b_data); end
    vectors++; if (fwd_a_hit !== 1'b1 || fwd_a_data !== 32'h77) begin miscompares++; $display("FAIL zero_fwd_a: got %0b/%0h expected 1/77", fwd_a_hit, fwd_a_data); end
    tick();
    vectors++; if (rf_we !== 1'b1 || rf_addr !== 5'd3 || rf_data !== 32'h77) begin miscompares++; $display("FAIL zero_commit: got %0b/%0d/%0h expected 1/3/77", rf_we, rf_addr, rf_data); end
    tick();
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL zero_no_second: got %0b expected 0", rf_we); end
  endtask

  task automatic test_backpressure();
    logic [36:0] exp_q[$];
    logic [36:0] want;
    int exp_cnt[6] = '{2, 3, 2, 3, 2, 3};
    int k = 0;
    int commits = 0;
    logic accept;
    address_rs = 0; address_rt = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 6) begin
        ld_valid = 1; ld_rd = 5'(8 + 2 * k); ld_data = 32'h100 + 32'(2 * k);
        alu_valid = 1; alu_rd = 5'(9 + 2 * k); alu_data = 32'h101 + 32'(2 * k);
      end else begin
        ld_valid = 0; alu_valid = 0;
      end
      accept = (c < 6) && in_ready;
      if (accept) begin
        exp_q.push_back({ld_rd, ld_data});
        exp_q.push_back({alu_rd, alu_data});
      end
      tick();
      if (accept) k++;
      if (c < 6) begin
        vectors++; if (count !== 5'(exp_cnt[c])) begin miscompares++; $display("FAIL bp_count[%0d]: got %0d expected %0d", c, count, exp_cnt[c]); end
        vectors++; if (in_ready !== (exp_cnt[c] <= 2)) begin miscompares++; $display("FAIL bp_ready[%0d]: got %0b expected %0b", c, in_ready, exp_cnt[c] <= 2); end
      end
      if (rf_we === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL bp_extra_commit: got rd %0d data %0h expected none", rf_addr, rf_data);
        end else begin
          want = exp_q.pop_front();
          if ({rf_addr, rf_data} !== want) begin miscompares++; $display("FAIL bp_commit[%0d]: got %0d/%0h expected %0d/%0h", commits, rf_addr, rf_data, want[36:32], want[31:0]); end
        end
        commits++;
      end
    end
    vectors++; if (commits != 8 || exp_q.size() != 0) begin miscompares++; $display("FAIL bp_total: got %0d commits, %0d left expected 8, 0", commits, exp_q.size()); end
  endtask

  task automatic test_wrap();
    int ci = 0;
    for (int i = 0; i < 23; i++) begin
      alu_valid = (i < 20); alu_rd = 5'(1 + i); alu_data = 32'h200 + 32'(i);
      tick();
      vectors++; if (count > 5'd1) begin miscompares++; $display("FAIL wrap_count[%0d]: got %0d expected <=1", i, count); end
      if (rf_we === 1'b1) begin
        vectors++;
        if ({rf_addr, rf_data} !== {5'(1 + ci), 32'h200 + 32'(ci)}) begin miscompares++; $display("FAIL wrap_commit[%0d]: got %0d/%0h expected %0d/%0h", ci, rf_addr, rf_data, 1 + ci, 32'h200 + 32'(ci)); end
        ci++;
      end
    end
    alu_valid = 0;
    vectors++; if (ci != 20) begin miscompares++; $display("FAIL wrap_total: got %0d expected 20", ci); end
  endtask

  task automatic test_reset_mid();
    ld_valid = 1; ld_rd = 5'd20; ld_data = 32'hC0;
    alu_valid = 1; alu_rd = 5'd21; alu_data = 32'hC1;
    tick();
    ld_rd = 5'd22; ld_data = 32'hC2; alu_rd = 5'd23; alu_data = 32'hC3;
    tick();
    ld_valid = 0; alu_valid = 0; address_rs = 5'd23; address_rt = 5'd20;
    vectors++; if (count !== 5'd3 || rf_we !== 1'b1) begin miscompares++; $display("FAIL mid_precondition: got count %0d we %0b expected 3 1", count, rf_we); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'd0) begin miscompares++; $display("FAIL mid_rf_clear: got %0b/%0d/%0h expected 0/0/0", rf_we, rf_addr, rf_data); end
    vectors++; if (count !== 5'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_count_clear: got %0d/%0b expected 0/1", count, in_ready); end
    vectors++; if (fwd_a_hit !== 1'b0 || fwd_a_data !== 32'd0 || fwd_b_hit !== 1'b0) begin miscompares++; $display("FAIL mid_fwd_clear: got %0b/%0h/%0b expected 0/0/0", fwd_a_hit, fwd_a_data, fwd_b_hit); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (rf_we !== 1'b0 || count !== 5'd0) begin miscompares++; $display("FAIL mid_stale[%0d]: got we %0b count %0d expected 0 0", i, rf_we, count); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    idle(2);
    test_dual();
    idle(2);
    test_reg_zero();
    idle(2);
    test_backpressure();
    idle(3);
    test_wrap();
    idle(3);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
